spi_ram_master: RTL
===================

Name: spi_ram_master

Overview:
- SPI initiator that writes pixel words into a remote `spi_ram_slave`-style RAM port.
- Frame format:
  - CS asserted low.
  - One 16-bit address word: upper 3 bits zero, lower 13 bits = start address.
  - N 16-bit data words; the responder auto-increments the address per word.
  - CS released.
- SPI mode 0, MSB first.
- Sits between a pixel stream producer and the SPI pins. Used for frame pushes between boards and as bench stimulus for the RAM slave.

Parameters:
- CLK_DIV, 4, clk cycles per SCK half-period; legal 2..255.
- GAP_CYCLES, 8, minimum clk cycles CS stays high between frames; legal 1..255.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request new frame; sampled only in IDLE
- start_addr  input  13  RAM address of first data word; captured on accepted start
- in_valid  input  1  in_data holds a word
- in_data  input  16  pixel word
- in_last  input  1  qualifies in_data as final word of frame
- in_ready  output  1  word accepted this cycle (transfer = in_valid & in_ready)
- spi_sck  output  1  SPI clock, idle low
- spi_cs  output  1  chip select, active low, idle high
- spi_mosi  output  1  serial data, MSB first
- busy  output  1  high from accepted start until return to IDLE
- done  output  1  one-cycle pulse on return to IDLE after a completed frame

Behaviour:
- Reset values: spi_cs=1, spi_sck=0, spi_mosi=0, in_ready=0, busy=0, done=0; FSM=IDLE, all counters 0.
- Reset applied mid-frame forces these values on the next clk edge. No partial-word completion.
- All outputs are registered.
- Bit timing:
  - Each bit = 2*CLK_DIV clk cycles: SCK low for CLK_DIV, then high for CLK_DIV.
  - spi_mosi updates on the first cycle of the low phase; the responder samples on the SCK rising edge.
- FSM states:
  - IDLE: `start`=1 → capture start_addr, busy=1, spi_cs=0, go CS_SETUP. `start` while busy is ignored.
  - CS_SETUP: CLK_DIV cycles with SCK low, mosi = address bit 15. Then go ADDR.
  - ADDR: shift out {3'b000, start_addr}, 16 bits.
    - On the final high phase's last cycle, if in_valid=1: in_ready=1 for one cycle, load in_data into the shift register, latch in_last, go DATA.
    - Else go STALL.
  - DATA: shift out 16 bits.
    - At word end, if latched last=1, go CS_HOLD.
    - Else, if in_valid=1, pulse in_ready, reload, stay DATA.
    - Else go STALL.
    - Back-to-back words produce no SCK gap.
  - STALL: spi_cs=0, spi_sck=0, mosi holds.
    - The first cycle in_valid=1: in_ready=1, load, go DATA. The first bit's low phase starts the next cycle.
  - CS_HOLD: CLK_DIV cycles with SCK low, CS low. Then spi_cs=1, go GAP.
  - GAP: GAP_CYCLES cycles with CS high. Then IDLE, busy=0, done=1 for one cycle.
- in_ready is never high outside ADDR/DATA word boundaries or STALL.
- in_valid/in_data/in_last are ignored when in_ready=0.
- Address counting is the responder's job; this block sends start_addr once per frame.
- A frame always carries at least one data word. A start followed by in_last on the first word is legal, giving a 32-bit frame.
- in_last on the first word together with a late in_valid goes through STALL normally.

Optional Feature:
- Macro: SPI_STALL_TIMEOUT_EN.
- Defined:
  - Adds parameter STALL_LIMIT (default 1024) and output `aborted` (1 bit).
  - When STALL has been occupied for STALL_LIMIT consecutive cycles, go to CS_HOLD, then GAP, then IDLE.
  - In that case `aborted` pulses for one cycle in place of `done`; done stays 0.
  - A stall count reaching STALL_LIMIT on the same cycle as in_valid=1: the word is accepted and there is no abort.
- Undefined: STALL waits indefinitely; the `aborted` port does not exist.

Test Plan:
- Single-word frame (CLK_DIV=4, GAP_CYCLES=8): start, start_addr=0x0005, in_data=0xA55A with in_last, valid all along → CS low for 4+256+4=264 cycles; 32 SCK rising edges; sampled MOSI = 0x0005 then 0xA55A; one in_ready pulse; done 8 cycles after CS rises.
- Burst: start_addr=0x1FFF, 4 words 0x0001,0x0002,0x0004,0x8000 with in_valid held high → 80 contiguous SCK cycles with no gap; 4 in_ready pulses, each at a word boundary; a model `spi_ram_slave` writes addresses 0x1FFF,0x0000,0x0001,0x0002 (13-bit wrap in slave).
- Stall: drop in_valid for 37 cycles between word 1 and word 2 → SCK held low and CS low for 37 cycles; word 2 begins the cycle after in_valid rises; data correct.
- Reset mid-frame: assert reset during bit 7 of data word 1 → next edge spi_cs=1, spi_sck=0, busy=0, no done; a fresh start afterwards produces a clean frame.
- Start while busy: pulse start during DATA with start_addr=0x0123 → ignored; current frame address unchanged; exactly one done.
- With SPI_STALL_TIMEOUT_EN, STALL_LIMIT=16: withhold second word → aborted pulses once; CS high after CS_HOLD; done stays 0; in_valid arriving on cycle 16 of stall prevents the abort.

Source files
------------

// File: rtl/spi_ram_master.sv
// SPI mode-0 initiator that pushes a 13-bit start address plus a stream of 16-bit words to a RAM responder.
// Optional SPI_STALL_TIMEOUT_EN adds STALL_LIMIT and an `aborted` pulse when the stream starves too long.
module spi_ram_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 8
`ifdef SPI_STALL_TIMEOUT_EN
  , parameter int unsigned STALL_LIMIT = 1024
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [12:0] start_addr,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        spi_sck,
  output logic        spi_cs,
  output logic        spi_mosi,
  output logic        busy,
  output logic        done
`ifdef SPI_STALL_TIMEOUT_EN
  , output logic      aborted
`endif
);

  localparam int unsigned CW = 8;
  localparam int unsigned BW = 4;
  localparam int unsigned DW = 16;

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, ADDR, DATA, STALL, CS_HOLD, GAP
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [DW-1:0]  shift_q, shift_d;
  logic           last_q, last_d;
  logic           sck_q, sck_d;
  logic           cs_q, cs_d;
  logic           mosi_q, mosi_d;
  logic           in_ready_q, in_ready_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           take_c;
  logic           load_c;
`ifdef SPI_STALL_TIMEOUT_EN
  localparam int unsigned SW = $clog2(STALL_LIMIT + 1);
  logic [SW-1:0]  stall_cnt_q, stall_cnt_d;
  logic           abort_q, abort_d;
  logic           aborted_q, aborted_d;
  assign aborted = aborted_q;
`endif

  assign in_ready = in_ready_q;
  assign spi_sck  = sck_q;
  assign spi_cs   = cs_q;
  assign spi_mosi = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SPI_STALL_TIMEOUT_EN
      stall_cnt_q <= '0;
      abort_q     <= 1'b0;
      aborted_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef SPI_STALL_TIMEOUT_EN
      stall_cnt_q <= stall_cnt_d;
      abort_q     <= abort_d;
      aborted_q   <= aborted_d;
`endif
    end
  end

  assign take_c = in_valid & in_ready_q;

  // Next-state and output decode; in_ready is raised one cycle ahead so it is high on the boundary cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    last_d     = last_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    in_ready_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load_c     = 1'b0;
`ifdef SPI_STALL_TIMEOUT_EN
    stall_cnt_d = '0;
    abort_d     = abort_q;
    aborted_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CS_SETUP;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          sck_d   = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = {2'b00, start_addr, 1'b0};
          mosi_d  = 1'b0;
          last_d  = 1'b0;
`ifdef SPI_STALL_TIMEOUT_EN
          abort_d = 1'b0;
`endif
        end
      end
      CS_SETUP: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          state_d = ADDR;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ADDR, DATA: begin
        if (cnt_q != CW'(CLK_DIV - 1)) begin
          cnt_d = cnt_q + CW'(1);
          if (sck_q && (bit_q == BW'(DW - 1)) && (cnt_q == CW'(CLK_DIV - 2)) &&
              ((state_q == ADDR) || !last_q)) begin
            in_ready_d = 1'b1;
          end
        end else if (!sck_q) begin
          sck_d = 1'b1;
          cnt_d = '0;
        end else if (bit_q != BW'(DW - 1)) begin
          sck_d   = 1'b0;
          cnt_d   = '0;
          bit_d   = bit_q + BW'(1);
          mosi_d  = shift_q[DW-1];
          shift_d = {shift_q[DW-2:0], 1'b0};
        end else begin
          sck_d = 1'b0;
          cnt_d = '0;
          bit_d = '0;
          if ((state_q == DATA) && last_q) begin
            state_d = CS_HOLD;
          end else if (take_c) begin
            load_c = 1'b1;
          end else begin
            state_d    = STALL;
            in_ready_d = 1'b1;
          end
        end
      end
      STALL: begin
        if (take_c) begin
          load_c = 1'b1;
`ifdef SPI_STALL_TIMEOUT_EN
        end else if (stall_cnt_q == SW'(STALL_LIMIT - 1)) begin
          state_d = CS_HOLD;
          cnt_d   = '0;
          abort_d = 1'b1;
`endif
        end else begin
          in_ready_d = 1'b1;
`ifdef SPI_STALL_TIMEOUT_EN
          stall_cnt_d = stall_cnt_q + SW'(1);
`endif
        end
      end
      CS_HOLD: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          state_d = GAP;
          cs_d    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
`ifdef SPI_STALL_TIMEOUT_EN
          if (abort_q) aborted_d = 1'b1;
          else         done_d    = 1'b1;
`else
          done_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Accepted word: its first bit's low phase begins next cycle
    if (load_c) begin
      state_d = DATA;
      shift_d = {in_data[DW-2:0], 1'b0};
      mosi_d  = in_data[DW-1];
      last_d  = in_last;
      bit_d   = '0;
      cnt_d   = '0;
      sck_d   = 1'b0;
    end
  end

endmodule
